// File: rtl/prog_truth_table.sv
// Reprogrammable N-input / M-output truth-table evaluator with a valid/ready eval path
// and a serial, MSB-first table loader that swaps the active table atomically on the last bit.
module prog_truth_table #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter logic [N_OUT*(1<<N_IN)-1:0] RULE = 8'h54,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN-1:0]   in_bits,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_OUT-1:0]  out_bits,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic [CNT_W-1:0]  eval_count
);

    localparam int DEPTH = 1 << N_IN;
    localparam int TBL_W = N_OUT * DEPTH;
    localparam int CW    = (TBL_W > 1) ? $clog2(TBL_W) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;

    logic [0:0]       state;
    logic [TBL_W-1:0] tbl;
    logic [TBL_W-1:0] shadow;
    logic [TBL_W-1:0] shadow_next;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             shift_en;
    logic             last_bit;
    logic [N_IN-1:0]  rev;
    logic [DEPTH-1:0] slice;
    logic [N_OUT-1:0] lookup;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign cfg_busy    = (state == LOAD);
    // cfg_start outranks a same-cycle cfg_valid, so that bit is dropped
    assign shift_en    = (state == LOAD) && cfg_valid && !cfg_start;
    assign last_bit    = shift_en && (cnt == CW'(TBL_W - 1));
    assign shadow_next = {shadow[TBL_W-2:0], cfg_bit};

    // Vector 0 selects the slice MSB, so the bit index is the inverted vector
    assign rev = ~in_bits;

    always_comb begin
        lookup = '0;
        slice  = '0;
        for (int k = 0; k < N_OUT; k++) begin
            slice     = tbl[k*DEPTH +: DEPTH];
            lookup[k] = slice[rev];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            tbl      <= RULE;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= last_bit;
            if (cfg_start) begin
                state  <= LOAD;
                cnt    <= '0;
                shadow <= '0;
            end else if (shift_en) begin
                shadow <= shadow_next;
                if (last_bit) begin
                    tbl   <= shadow_next;
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Accepts on the commit edge still read the old table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_bits   <= '0;
            out_valid  <= 1'b0;
            eval_count <= '0;
        end else if (accept) begin
            out_bits  <= lookup;
            out_valid <= 1'b1;
            if (eval_count != '1) begin
                eval_count <= eval_count + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
